// File: rtl/dmem_bytelane_if.sv
// dmem_bytelane_if: request/response channel of the byte-lane data memory.
// The master issues loads and stores; the slave (the memory) answers one cycle
// after each accepted request.
interface dmem_bytelane_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_write, req_funct3, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_write, req_funct3, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/dmem_bytelane.sv
// dmem_bytelane: RV32 data memory with byte-lane stores, sign/zero-extended
// loads, a valid/ready request channel with a registered one-cycle response,
// misalign/range/funct3 error reporting and a zero-fill clear sweep.
// Optional macro DMEM_LA_PORT_EN adds a logic-analyser word read port
// (la_dram_select / la_read_data).
module dmem_bytelane #(
    parameter  int DEPTH = 16,
    localparam int IDX_W = $clog2(DEPTH)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clr,
    dmem_bytelane_if.slave      bus,
`ifdef DMEM_LA_PORT_EN
    input  logic [IDX_W-1:0]    la_dram_select,
    output logic [31:0]         la_read_data,
`endif
    output logic                busy
);

    localparam logic [0:0] S_CLEAR = 1'b0;
    localparam logic [0:0] S_IDLE  = 1'b1;

    logic [0:0]       state;
    logic [IDX_W-1:0] cnt;
    logic [31:0]      mem [DEPTH];

    logic             ready;
    logic             accept;
    logic [IDX_W-1:0] idx;
    logic             range_err;
    logic             misalign_err;
    logic             funct_err;
    logic             req_err;
    logic             do_write;
    logic [3:0]       lane_en;
    logic [31:0]      wrep;
    logic [31:0]      rword;
    logic [31:0]      load_val;

    // Right-align the addressed byte/half of a word and extend it per funct3.
    function automatic logic [31:0] load_extend(input logic [31:0] word,
                                                input logic [2:0]  f3,
                                                input logic [1:0]  off);
        logic        [31:0] shifted;
        logic signed [7:0]  b;
        logic signed [15:0] h;
        shifted = word >> {off, 3'b000};
        b = shifted[7:0];
        h = shifted[15:0];
        case (f3)
            3'b000:  return {{24{b[7]}}, b};
            3'b001:  return {{16{h[15]}}, h};
            3'b100:  return {24'h0, b};
            3'b101:  return {16'h0, h};
            default: return word;
        endcase
    endfunction

    assign busy          = (state == S_CLEAR);
    assign ready         = (state == S_IDLE) && !clr;
    assign bus.req_ready = ready;
    assign accept        = bus.req_valid && ready;

    // Request decode: word index, error classification, lane enables, store data.
    always_comb begin
        idx       = bus.req_addr[IDX_W+1:2];
        range_err = |bus.req_addr[31:IDX_W+2];

        misalign_err = 1'b0;
        case (bus.req_funct3[1:0])
            2'b01:   misalign_err = bus.req_addr[0];
            2'b10:   misalign_err = |bus.req_addr[1:0];
            default: misalign_err = 1'b0;
        endcase

        if (bus.req_write)
            funct_err = bus.req_funct3[2] || (bus.req_funct3[1:0] == 2'b11);
        else
            funct_err = (bus.req_funct3 == 3'b011) || (bus.req_funct3[2:1] == 2'b11);

        req_err  = range_err || misalign_err || funct_err;
        do_write = accept && bus.req_write && !req_err;

        lane_en = 4'b1111;
        wrep    = bus.req_wdata;
        case (bus.req_funct3[1:0])
            2'b00: begin
                lane_en = 4'b0001 << bus.req_addr[1:0];
                wrep    = {4{bus.req_wdata[7:0]}};
            end
            2'b01: begin
                lane_en = bus.req_addr[1] ? 4'b1100 : 4'b0011;
                wrep    = {2{bus.req_wdata[15:0]}};
            end
            default: begin
                lane_en = 4'b1111;
                wrep    = bus.req_wdata;
            end
        endcase

        rword    = mem[idx];
        load_val = load_extend(rword, bus.req_funct3, bus.req_addr[1:0]);
    end

    // Clear sequencer: sweep every word to zero, then serve requests in IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_CLEAR;
            cnt   <= '0;
        end else begin
            case (state)
                S_CLEAR: begin
                    if (cnt == IDX_W'(DEPTH - 1))
                        state <= S_IDLE;
                    cnt <= cnt + 1'b1;
                end
                default: begin
                    if (clr) begin
                        state <= S_CLEAR;
                        cnt   <= '0;
                    end
                end
            endcase
        end
    end

    // Storage: sweep writes zero; accepted error-free stores update selected lanes.
    always_ff @(posedge clk) begin
        if (state == S_CLEAR) begin
            mem[cnt] <= '0;
        end else if (do_write) begin
            for (int l = 0; l < 4; l++)
                if (lane_en[l])
                    mem[idx][8*l +: 8] <= wrep[8*l +: 8];
        end
    end

    // Registered response, one cycle after accept; data only for good loads.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.rsp_valid <= 1'b0;
            bus.rsp_err   <= 1'b0;
            bus.rsp_rdata <= '0;
        end else begin
            bus.rsp_valid <= accept;
            bus.rsp_err   <= accept && req_err;
            bus.rsp_rdata <= (accept && !req_err && !bus.req_write) ? load_val : 32'h0;
        end
    end

`ifdef DMEM_LA_PORT_EN
    // Debug port: free-running registered read of the selected word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            la_read_data <= '0;
        else
            la_read_data <= mem[la_dram_select];
    end
`endif

endmodule

// File: tb/tb_dmem_bytelane.sv
// tb_dmem_bytelane: table-driven directed vectors, reset/clear corner-case
// sequences and randomized traffic checked against a byte-array reference model.
module tb_dmem_bytelane;
    localparam int DEPTH = 16;
    localparam int IDX_W = $clog2(DEPTH);

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    logic clr   = 1'b0;
    logic busy;

    dmem_bytelane_if bus();

`ifdef DMEM_LA_PORT_EN
    logic [IDX_W-1:0] la_dram_select = '0;
    logic [31:0]      la_read_data;
`endif

    dmem_bytelane #(.DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .clr            (clr),
        .bus            (bus),
`ifdef DMEM_LA_PORT_EN
        .la_dram_select (la_dram_select),
        .la_read_data   (la_read_data),
`endif
        .busy           (busy)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    byte unsigned ref_mem [DEPTH*4];

    typedef struct {
        logic        wr;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs [21];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h want %08h", name, act, exp);
        end
    endtask

    // Reference model: memory as a flat little-endian byte array.
    function automatic void model(input logic wr, input logic [2:0] f3,
                                  input logic [31:0] a, input logic [31:0] d,
                                  output logic [31:0] rd, output logic e);
        int unsigned n;
        int unsigned s;
        logic [31:0] v;
        logic illegal;
        n = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : (f3[1:0] == 2'd2) ? 4 : 0;
        if (wr) illegal = (f3 > 3'd2);
        else    illegal = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7);
        e  = illegal || (a >= DEPTH*4) || (n == 0) || ((a % n) != 0);
        rd = 32'h0;
        if (!e) begin
            if (wr) begin
                for (int k = 0; k < n; k++) ref_mem[a + k] = d[8*k +: 8];
            end else begin
                v = 32'h0;
                for (int k = 0; k < n; k++) v = v + (32'(ref_mem[a + k]) << (8*k));
                if (!f3[2] && n < 4) begin
                    s = 32'h1 << (8*n - 1);
                    v = (v ^ s) - s;
                end
                rd = v;
            end
        end
    endfunction

    task automatic xfer(input logic wr, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] d, output logic [31:0] rd,
                        output logic e, output logic v);
        bus.req_valid  = 1'b1;
        bus.req_write  = wr;
        bus.req_funct3 = f3;
        bus.req_addr   = a;
        bus.req_wdata  = d;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        @(negedge clk);
        v  = bus.rsp_valid;
        rd = bus.rsp_rdata;
        e  = bus.rsp_err;
    endtask

    // Count consecutive busy cycles (bounded); optionally pulse clr mid-sweep.
    task automatic sweep_len(input int clr_at, output int n, output int rdy_bad);
        n = 0;
        rdy_bad = 0;
        for (int i = 0; i < 100; i++) begin
            if (!busy) break;
            n++;
            if (bus.req_ready) rdy_bad++;
            clr = (i == clr_at);
            @(negedge clk);
        end
        clr = 1'b0;
    endtask

    initial begin
        logic [31:0] rd, mrd, a, d;
        logic        e, v, me, wr;
        logic [2:0]  f3;
        int          n, rb;

        bus.req_valid  = 1'b0;
        bus.req_write  = 1'b0;
        bus.req_funct3 = 3'b0;
        bus.req_addr   = 32'h0;
        bus.req_wdata  = 32'h0;
        for (int i = 0; i < DEPTH*4; i++) ref_mem[i] = 8'h0;

        vecs[0]  = '{1'b0, 3'b010, 32'h3C, 32'h0,        32'h00000000, 1'b0};
        vecs[1]  = '{1'b1, 3'b010, 32'h08, 32'h11223344, 32'h00000000, 1'b0};
        vecs[2]  = '{1'b1, 3'b000, 32'h09, 32'h000000AB, 32'h00000000, 1'b0};
        vecs[3]  = '{1'b0, 3'b010, 32'h08, 32'h0,        32'h1122AB44, 1'b0};
        vecs[4]  = '{1'b0, 3'b000, 32'h09, 32'h0,        32'hFFFFFFAB, 1'b0};
        vecs[5]  = '{1'b0, 3'b100, 32'h09, 32'h0,        32'h000000AB, 1'b0};
        vecs[6]  = '{1'b1, 3'b001, 32'h12, 32'h00008001, 32'h00000000, 1'b0};
        vecs[7]  = '{1'b0, 3'b001, 32'h12, 32'h0,        32'hFFFF8001, 1'b0};
        vecs[8]  = '{1'b0, 3'b101, 32'h12, 32'h0,        32'h00008001, 1'b0};
        vecs[9]  = '{1'b0, 3'b010, 32'h10, 32'h0,        32'h80010000, 1'b0};
        vecs[10] = '{1'b0, 3'b010, 32'h06, 32'h0,        32'h00000000, 1'b1};
        vecs[11] = '{1'b1, 3'b001, 32'h11, 32'h00005555, 32'h00000000, 1'b1};
        vecs[12] = '{1'b0, 3'b010, 32'h10, 32'h0,        32'h80010000, 1'b0};
        vecs[13] = '{1'b0, 3'b010, 32'h40, 32'h0,        32'h00000000, 1'b1};
        vecs[14] = '{1'b1, 3'b100, 32'h20, 32'hCAFEF00D, 32'h00000000, 1'b1};
        vecs[15] = '{1'b0, 3'b010, 32'h20, 32'h0,        32'h00000000, 1'b0};
        vecs[16] = '{1'b0, 3'b011, 32'h00, 32'h0,        32'h00000000, 1'b1};
        vecs[17] = '{1'b0, 3'b000, 32'h0B, 32'h0,        32'h00000011, 1'b0};
        vecs[18] = '{1'b0, 3'b001, 32'h08, 32'h0,        32'hFFFFAB44, 1'b0};
        vecs[19] = '{1'b0, 3'b101, 32'h0A, 32'h0,        32'h00001122, 1'b0};
        vecs[20] = '{1'b1, 3'b010, 32'h0C, 32'h00000000, 32'h00000000, 1'b0};

        // Power-on reset and initial sweep
        #3 rst_n = 1'b0;
        #1;
        check("reset_busy",      32'(busy),          32'h1);
        check("reset_ready",     32'(bus.req_ready), 32'h0);
        check("reset_rsp_valid", 32'(bus.rsp_valid), 32'h0);
        check("reset_rsp_err",   32'(bus.rsp_err),   32'h0);
        check("reset_rsp_rdata", bus.rsp_rdata,      32'h0);
`ifdef DMEM_LA_PORT_EN
        check("reset_la",        la_read_data,       32'h0);
`endif
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        sweep_len(-1, n, rb);
        check("init_sweep_len", 32'(n),  32'd16);
        check("init_sweep_rdy", 32'(rb), 32'd0);

        // Directed vectors
        for (int i = 0; i < 21; i++) begin
            model(vecs[i].wr, vecs[i].f3, vecs[i].addr, vecs[i].wdata, mrd, me);
            xfer(vecs[i].wr, vecs[i].f3, vecs[i].addr, vecs[i].wdata, rd, e, v);
            check($sformatf("vec%0d_valid", i), 32'(v), 32'h1);
            check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
            check($sformatf("vec%0d_err", i), 32'(e), 32'(vecs[i].exp_err));
        end

        // No request -> no response
        @(negedge clk);
        check("idle_rsp_valid", 32'(bus.rsp_valid), 32'h0);

        // Randomized traffic against the reference model
        for (int i = 0; i < 400; i++) begin
            wr = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) != 0) begin
                f3 = wr ? 3'($urandom_range(0, 2)) : 3'($urandom_range(0, 5));
                if (!wr && f3 == 3'd3) f3 = 3'd4;
            end else begin
                f3 = 3'($urandom_range(0, 7));
            end
            a = 32'($urandom_range(0, DEPTH*4 - 1));
            if ($urandom_range(0, 1) != 0) a = a & ~32'(f3[1:0] == 2'd2 ? 3 : f3[1:0]);
            if ($urandom_range(0, 9) == 0) a = a | (32'h1 << $urandom_range(IDX_W + 2, 31));
            d = $urandom;
            model(wr, f3, a, d, mrd, me);
            xfer(wr, f3, a, d, rd, e, v);
            check($sformatf("rnd%0d_valid", i), 32'(v), 32'h1);
            check($sformatf("rnd%0d_rdata", i), rd, mrd);
            check($sformatf("rnd%0d_err", i), 32'(e), 32'(me));
        end

        // Logic-analyser port sees a fresh store one edge after selection
        model(1'b1, 3'b010, 32'h14, 32'hDEADBEEF, mrd, me);
        xfer(1'b1, 3'b010, 32'h14, 32'hDEADBEEF, rd, e, v);
        check("la_store_err", 32'(e), 32'h0);
`ifdef DMEM_LA_PORT_EN
        la_dram_select = IDX_W'(5);
        @(posedge clk);
        #1;
        check("la_read", la_read_data, 32'hDEADBEEF);
        @(negedge clk);
`endif

        // clr and req_valid together: clr wins; clr during sweep is ignored
        bus.req_valid  = 1'b1;
        bus.req_write  = 1'b0;
        bus.req_funct3 = 3'b010;
        bus.req_addr   = 32'h14;
        clr = 1'b1;
        #1;
        check("coll_ready", 32'(bus.req_ready), 32'h0);
        @(posedge clk);
        #1;
        clr = 1'b0;
        bus.req_valid = 1'b0;
        @(negedge clk);
        check("coll_no_rsp", 32'(bus.rsp_valid), 32'h0);
        sweep_len(6, n, rb);
        check("coll_sweep_len", 32'(n),  32'd16);
        check("coll_sweep_rdy", 32'(rb), 32'd0);
        for (int i = 0; i < DEPTH*4; i++) ref_mem[i] = 8'h0;
        for (int w = 0; w < DEPTH; w++) begin
            xfer(1'b0, 3'b010, 32'(4*w), 32'h0, rd, e, v);
            check($sformatf("clr_word%0d", w), rd, 32'h0);
        end

        // Asynchronous reset while a response is showing
        xfer(1'b1, 3'b010, 32'h14, 32'hDEADBEEF, rd, e, v);
        bus.req_valid  = 1'b1;
        bus.req_write  = 1'b0;
        bus.req_funct3 = 3'b010;
        bus.req_addr   = 32'h14;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        #1;
        check("pre_rst_valid", 32'(bus.rsp_valid), 32'h1);
        check("pre_rst_rdata", bus.rsp_rdata,      32'hDEADBEEF);
        rst_n = 1'b0;
        #1;
        check("arst_valid", 32'(bus.rsp_valid), 32'h0);
        check("arst_rdata", bus.rsp_rdata,      32'h0);
        check("arst_busy",  32'(busy),          32'h1);
`ifdef DMEM_LA_PORT_EN
        check("arst_la",    la_read_data,       32'h0);
`endif
        @(negedge clk);
        rst_n = 1'b1;

        // Reset again at sweep cycle 5: the sweep restarts for a full length
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy", 32'(busy), 32'h1);
        @(negedge clk);
        rst_n = 1'b1;
        sweep_len(-1, n, rb);
        check("mid_rst_sweep_len", 32'(n),  32'd16);
        check("mid_rst_sweep_rdy", 32'(rb), 32'd0);
        xfer(1'b0, 3'b010, 32'h14, 32'h0, rd, e, v);
        check("post_rst_rdata", rd,      32'h0);
        check("post_rst_err",   32'(e),  32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
